// File: rtl/local_port_adapter.sv
// Network-interface endpoint that bridges a core's push/pop FIFOs to a switch local port using 4-phase handshakes.
// Optional build macro NI_ADDR_CHECK_EN: also discard RX flits whose address differs from ADDR.
module local_port_adapter #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 4,
  parameter int ADDR      = 0,
  parameter int TX_LOG2   = 2,
  parameter int RX_LOG2   = 2
) (
  input  logic                               clk,
  input  logic                               a_rst,
  input  logic                               tx_valid,
  input  logic [ADDR_SIZE-1:0]               tx_addr,
  input  logic [DATA_SIZE-1:0]               tx_data,
  output logic                               tx_ready,
  output logic                               rx_valid,
  output logic [ADDR_SIZE-1:0]               rx_addr,
  output logic [DATA_SIZE-1:0]               rx_data,
  input  logic                               rx_ack,
  output logic [DATA_SIZE+ADDR_SIZE:0]       sw_data_o,
  output logic                               sw_wr_ready_out,
  input  logic                               sw_r_ready_in,
  input  logic [DATA_SIZE+ADDR_SIZE:0]       sw_data_i,
  input  logic                               sw_wr_ready_in,
  output logic                               sw_r_ready_out,
  output logic                               err_addr
);
  localparam int BUS_SIZE = DATA_SIZE + ADDR_SIZE + 1;
  localparam int PL_SIZE  = DATA_SIZE + ADDR_SIZE;
  localparam int TX_DEPTH = 1 << TX_LOG2;
  localparam int RX_DEPTH = 1 << RX_LOG2;

  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_REL} tx_state_e;
  typedef enum logic {RX_WAIT, RX_ACK} rx_state_e;

  tx_state_e tx_state_q;
  rx_state_e rx_state_q;

  // ---------------- TX FIFO (core -> switch) ----------------
  logic [PL_SIZE-1:0] tx_mem [TX_DEPTH];
  logic [TX_LOG2:0]   tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic               tx_empty, tx_full, tx_push, tx_pop;
  logic [PL_SIZE-1:0] tx_head;

  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[TX_LOG2] != tx_rd_q[TX_LOG2]) &&
                    (tx_wr_q[TX_LOG2-1:0] == tx_rd_q[TX_LOG2-1:0]);
  assign tx_ready = ~tx_full;
  assign tx_push  = tx_valid & ~tx_full;
  assign tx_head  = tx_mem[tx_rd_q[TX_LOG2-1:0]];
  // A new request may only start once the switch has released its previous acknowledge.
  assign tx_pop   = ~tx_empty & ~sw_r_ready_in &
                    ((tx_state_q == TX_IDLE) | (tx_state_q == TX_REL));
  assign tx_wr_d  = tx_wr_q + (TX_LOG2+1)'(tx_push);
  assign tx_rd_d  = tx_rd_q + (TX_LOG2+1)'(tx_pop);

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q[TX_LOG2-1:0]] <= {tx_addr, tx_data};
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      tx_wr_q <= '0;
      tx_rd_q <= '0;
    end else begin
      tx_wr_q <= tx_wr_d;
      tx_rd_q <= tx_rd_d;
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      tx_state_q      <= TX_IDLE;
      sw_wr_ready_out <= 1'b0;
      sw_data_o       <= '0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_pop) begin
            sw_data_o       <= {1'b1, tx_head};
            sw_wr_ready_out <= 1'b1;
            tx_state_q      <= TX_REQ;
          end
        end
        TX_REQ: begin
          if (sw_r_ready_in) begin
            sw_wr_ready_out <= 1'b0;
            tx_state_q      <= TX_REL;
          end
        end
        TX_REL: begin
          if (!sw_r_ready_in) begin
            if (tx_pop) begin
              sw_data_o       <= {1'b1, tx_head};
              sw_wr_ready_out <= 1'b1;
              tx_state_q      <= TX_REQ;
            end else begin
              tx_state_q      <= TX_IDLE;
            end
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO (switch -> core) ----------------
  logic [PL_SIZE-1:0] rx_mem [RX_DEPTH];
  logic [RX_LOG2:0]   rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic               rx_empty, rx_full, rx_fire, rx_keep, rx_push, rx_pop;
  logic [PL_SIZE-1:0] rx_head;

  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[RX_LOG2] != rx_rd_q[RX_LOG2]) &&
                    (rx_wr_q[RX_LOG2-1:0] == rx_rd_q[RX_LOG2-1:0]);
  assign rx_fire  = (rx_state_q == RX_WAIT) & sw_wr_ready_in & ~rx_full;
`ifdef NI_ADDR_CHECK_EN
  localparam logic [ADDR_SIZE-1:0] MY_ADDR = ADDR_SIZE'(ADDR);
  assign rx_keep  = sw_data_i[BUS_SIZE-1] & (sw_data_i[PL_SIZE-1:DATA_SIZE] == MY_ADDR);
`else
  assign rx_keep  = sw_data_i[BUS_SIZE-1];
`endif
  assign rx_push  = rx_fire & rx_keep;
  assign rx_pop   = rx_ack & ~rx_empty;
  assign rx_wr_d  = rx_wr_q + (RX_LOG2+1)'(rx_push);
  assign rx_rd_d  = rx_rd_q + (RX_LOG2+1)'(rx_pop);

  assign rx_valid = ~rx_empty;
  assign rx_head  = rx_mem[rx_rd_q[RX_LOG2-1:0]];
  // Head is gated so the outputs read as zero whenever nothing is queued.
  assign rx_addr  = rx_valid ? rx_head[PL_SIZE-1:DATA_SIZE] : '0;
  assign rx_data  = rx_valid ? rx_head[DATA_SIZE-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_q[RX_LOG2-1:0]] <= sw_data_i[PL_SIZE-1:0];
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      rx_wr_q <= '0;
      rx_rd_q <= '0;
    end else begin
      rx_wr_q <= rx_wr_d;
      rx_rd_q <= rx_rd_d;
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      rx_state_q     <= RX_WAIT;
      sw_r_ready_out <= 1'b0;
      err_addr       <= 1'b0;
    end else begin
      err_addr <= 1'b0;
      case (rx_state_q)
        RX_WAIT: begin
          if (rx_fire) begin
            sw_r_ready_out <= 1'b1;
            err_addr       <= ~rx_keep;
            rx_state_q     <= RX_ACK;
          end
        end
        RX_ACK: begin
          if (!sw_wr_ready_in) begin
            sw_r_ready_out <= 1'b0;
            rx_state_q     <= RX_WAIT;
          end
        end
        default: rx_state_q <= RX_WAIT;
      endcase
    end
  end
endmodule
